// File: rtl/clint_mtime_if.sv
// AXI4-Lite read-only channel (AR + R) between the bus arbiter and clint_mtime.
interface clint_mtime_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/clint_mtime.sv
// Free-running 64-bit mtime exposed as two read-only AXI4-Lite words.
// Optional macro CLINT_HI_LATCH_EN: low-word read snapshots the high word for a tear-free 64-bit read.
//
// state   | meaning
// --------+------------------------------------------------------
// ST_IDLE | arready=1, waiting for an AR handshake
// ST_RESP | rvalid=1, rdata/rresp held until rready is sampled
module clint_mtime #(
  parameter logic [31:0] MTIME_LO_ADDR = 32'hA000_0048,
  parameter logic [31:0] MTIME_HI_ADDR = 32'hA000_004C
) (
  input  logic         clock,
  input  logic         reset,
  clint_mtime_if.slave bus
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  state_e      state_q;
  logic [63:0] mtime_q;
  logic [63:0] mtime_d;
  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;
  logic [1:0]  rresp_q;
  logic [1:0]  rresp_d;
  logic [31:0] hi_word;
  logic        hit_lo;
  logic        hit_hi;

  // Counter never stalls; the full 64-bit add carries across the word boundary in one edge.
  assign mtime_d = mtime_q + 64'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      mtime_q <= '0;
    end else begin
      mtime_q <= mtime_d;
    end
  end

  assign hit_lo = (bus.araddr == MTIME_LO_ADDR);
  assign hit_hi = (bus.araddr == MTIME_HI_ADDR);

`ifdef CLINT_HI_LATCH_EN
  logic [31:0] shadow_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q <= '0;
    end else if ((state_q == ST_IDLE) && bus.arvalid && hit_lo) begin
      shadow_q <= mtime_q[63:32];
    end
  end

  assign hi_word = shadow_q;
`else
  assign hi_word = mtime_q[63:32];
`endif

  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_SLVERR;
    if (hit_lo) begin
      rdata_d = mtime_q[31:0];
      rresp_d = RESP_OKAY;
    end else if (hit_hi) begin
      rdata_d = hi_word;
      rresp_d = RESP_OKAY;
    end
  end

  // rdata/rresp keep the last response after the R handshake until the next AR handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.arvalid) begin
            state_q   <= ST_RESP;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
          end
        end
        ST_RESP: begin
          if (bus.rready) begin
            state_q   <= ST_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

endmodule

// File: tb/tb_clint_mtime.sv
// Self-checking bench for clint_mtime: directed table, corner sequences and randomized traffic vs a model.
module tb_clint_mtime;

  localparam logic [31:0] LO = 32'hA000_0048;
  localparam logic [31:0] HI = 32'hA000_004C;

  logic clock = 1'b0;
  logic reset = 1'b1;

  clint_mtime_if bus_if ();

  clint_mtime dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: mtime is simply the number of non-reset edges since the last reset edge.
  logic [63:0] m_time   = '0;
  bit          m_busy   = 1'b0;
  logic [31:0] m_data   = '0;
  logic [1:0]  m_resp   = '0;
  logic [31:0] m_shadow = '0;
  logic [63:0] bd_val   = '0;

  typedef struct {
    logic [31:0] addr;
    int          hold;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_time   = '0;
      m_busy   = 1'b0;
      m_data   = '0;
      m_resp   = '0;
      m_shadow = '0;
    end else begin
      if (!m_busy && bus_if.arvalid) begin
        m_busy = 1'b1;
        if (bus_if.araddr == LO) begin
          m_data   = m_time[31:0];
          m_resp   = 2'b00;
          m_shadow = m_time[63:32];
        end else if (bus_if.araddr == HI) begin
`ifdef CLINT_HI_LATCH_EN
          m_data = m_shadow;
`else
          m_data = m_time[63:32];
`endif
          m_resp = 2'b00;
        end else begin
          m_data = '0;
          m_resp = 2'b10;
        end
      end else if (m_busy && bus_if.rready) begin
        m_busy = 1'b0;
      end
      m_time = m_time + 64'd1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("arready", 64'(bus_if.arready), 64'(!m_busy));
      check("rvalid", 64'(bus_if.rvalid), 64'(m_busy));
      check("mtime", dut.mtime_q, m_time);
      if (m_busy) begin
        check("rdata", 64'(bus_if.rdata), 64'(m_data));
        check("rresp", 64'(bus_if.rresp), 64'(m_resp));
      end
    end
  end

  // Called at a falling edge; loads mtime well before the next rising edge.
  task automatic backdoor(input logic [63:0] v);
    #2;
    bd_val = v;
    force dut.mtime_q = bd_val;
    m_time = v;
    #1;
    release dut.mtime_q;
  endtask

  // Called at a falling edge in IDLE; returns at the falling edge after the R handshake.
  task automatic do_read(input logic [31:0] a, input int hold,
                         output logic [31:0] d, output logic [1:0] r);
    bus_if.araddr  = a;
    bus_if.arvalid = 1'b1;
    bus_if.rready  = 1'b0;
    @(negedge clock);
    bus_if.arvalid = 1'b0;
    check("rd_rvalid", 64'(bus_if.rvalid), 64'd1);
    d = bus_if.rdata;
    r = bus_if.rresp;
    repeat (hold) begin
      @(negedge clock);
      check("hold_arready", 64'(bus_if.arready), 64'd0);
    end
    bus_if.rready = 1'b1;
    @(negedge clock);
    bus_if.rready = 1'b0;
    check("rd_done_rvalid", 64'(bus_if.rvalid), 64'd0);
    check("rd_done_arready", 64'(bus_if.arready), 64'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] exp_lo;
    logic [31:0] a;
    int          guard;

    vecs[0] = '{LO,           0, 2'b00};
    vecs[1] = '{HI,           2, 2'b00};
    vecs[2] = '{32'hA000_0050, 0, 2'b10};
    vecs[3] = '{32'hA000_0044, 1, 2'b10};
    vecs[4] = '{32'h0000_0000, 0, 2'b10};
    vecs[5] = '{32'hA000_0049, 0, 2'b10};
    vecs[6] = '{32'hFFFF_FFFF, 0, 2'b10};
    vecs[7] = '{32'h2000_0048, 0, 2'b10};
    vecs[8] = '{LO,           3, 2'b00};
    vecs[9] = '{HI,           0, 2'b00};

    bus_if.araddr  = '0;
    bus_if.arvalid = 1'b0;
    bus_if.rready  = 1'b0;
    reset          = 1'b1;

    // Reset defaults
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_en = 1'b1;
    check("rst_arready", 64'(bus_if.arready), 64'd1);
    check("rst_rvalid", 64'(bus_if.rvalid), 64'd0);
    check("rst_rdata", 64'(bus_if.rdata), 64'd0);
    check("rst_rresp", 64'(bus_if.rresp), 64'd0);
    reset = 1'b0;

    // Low read with the handshake at mtime == 10
    guard = 0;
    while (m_time != 64'd10 && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    check("mtime_at_10", dut.mtime_q, 64'd10);
    do_read(LO, 0, d, r);
    check("low_read_data", 64'(d), 64'h0000_000A);
    check("low_read_resp", 64'(r), 64'd0);

    // Held response: data is the value sampled at the AR handshake
    exp_lo = m_time[31:0];
    do_read(LO, 5, d, r);
    check("held_data", 64'(d), 64'(exp_lo));

    // Bad address then a good read
    do_read(32'hA000_0050, 0, d, r);
    check("bad_rdata", 64'(d), 64'd0);
    check("bad_rresp", 64'(r), 64'h2);
    exp_lo = m_time[31:0];
    do_read(LO, 0, d, r);
    check("after_bad_resp", 64'(r), 64'd0);
    check("after_bad_data", 64'(d), 64'(exp_lo));

    // Carry from bit 31 into bit 32
`ifdef CLINT_HI_LATCH_EN
    backdoor(64'h0000_0000_FFFF_FFFF);
    do_read(LO, 0, d, r);
    check("carry_lo", 64'(d), 64'hFFFF_FFFF);
    do_read(HI, 0, d, r);
    check("carry_hi_shadow", 64'(d), 64'h0);
`else
    backdoor(64'h0000_0000_FFFF_FFFF);
    @(negedge clock);
    do_read(HI, 0, d, r);
    check("carry_hi", 64'(d), 64'h1);
`endif

    // Wrap of the full 64-bit counter
    backdoor(64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clock);
    check("wrap", dut.mtime_q, 64'd0);

    // Table of directed reads
    for (int i = 0; i < 10; i++) begin
      do_read(vecs[i].addr, vecs[i].hold, d, r);
      check($sformatf("vec%0d_resp", i), 64'(r), 64'(vecs[i].exp_resp));
      if (vecs[i].exp_resp == 2'b10) check($sformatf("vec%0d_zero", i), 64'(d), 64'd0);
    end

    // Reset during RESP
    bus_if.araddr  = LO;
    bus_if.arvalid = 1'b1;
    @(negedge clock);
    bus_if.arvalid = 1'b0;
    check("pre_rst_rvalid", 64'(bus_if.rvalid), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_rvalid", 64'(bus_if.rvalid), 64'd0);
    check("midrst_arready", 64'(bus_if.arready), 64'd1);
    check("midrst_mtime", dut.mtime_q, 64'd0);
    reset = 1'b0;

    // Randomized traffic, occasional resets and backdoor loads near the word boundary
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: a = LO;
        1: a = HI;
        2: a = $urandom();
        default: a = LO ^ (32'h1 << $urandom_range(0, 31));
      endcase
      bus_if.araddr  = a;
      bus_if.arvalid = 1'($urandom_range(0, 1));
      bus_if.rready  = 1'($urandom_range(0, 1));
      reset          = ($urandom_range(0, 199) == 0);
      if ((i % 500) == 250) backdoor({32'($urandom()), 32'hFFFF_FFF8});
      @(negedge clock);
    end

    bus_if.arvalid = 1'b0;
    bus_if.rready  = 1'b1;
    reset          = 1'b0;
    repeat (3) @(negedge clock);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
